conv_feeder: RTL and testbench
==============================

CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameters SHALL be: XSIZE, default 8, x-vector length; FSIZE, default 4, f-vector length; LOGX, default 3, x address width; LOGF, default 2, f address width.
REQ-002 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ld_wr_en  input  1  write strobe for the vector load port.
REQ-005 ld_sel  input  1  load target: 0 = x memory, 1 = f memory.
REQ-006 ld_addr  input  LOGX  load address; for f, only the low LOGF bits are used.
REQ-007 ld_data  input  8  signed load data.
REQ-008 start  input  1  single-cycle request to stream both stored vectors.
REQ-009 busy  output  1  high from the accepted start until done.
REQ-010 done  output  1  one-cycle pulse when both channels have finished.
REQ-011 m_data_out_x / m_valid_x / m_ready_x  output 8 / output 1 / input 1  x stream, master side.
REQ-012 m_data_out_f / m_valid_f / m_ready_f  output 8 / output 1 / input 1  f stream, master side.

Function
REQ-013 A load write SHALL occur when ld_wr_en=1 and busy=0; the write SHALL be ignored when busy=1, or when ld_sel=1 and ld_addr>=FSIZE.
REQ-014 The FSM SHALL have the states IDLE, PREFETCH, STREAM and FINISH.
REQ-015 start SHALL be accepted only in IDLE: IDLE->PREFETCH; start in any other state SHALL be ignored.
REQ-016 PREFETCH SHALL last exactly one cycle to cover the 1-cycle registered memory read; m_valid_x and m_valid_f SHALL first assert 2 cycles after the start edge.
REQ-017 A transfer SHALL occur on a channel only when m_valid and m_ready are both high at a rising clock edge.
REQ-018 While m_valid=1 and m_ready=0, m_data_out SHALL hold stable and m_valid SHALL NOT drop.
REQ-019 With m_ready held at 1, a channel SHALL transfer one element per cycle without bubbles, which requires read-ahead plus a skid/output register.
REQ-020 Elements SHALL be sent in address order 0..SIZE-1; each channel SHALL deassert m_valid in the cycle after its last transfer.
REQ-021 The channels SHALL be independent; one channel finishing or stalling SHALL NOT affect the other.
REQ-022 STREAM->FINISH SHALL occur when both channels have completed; in FINISH, done=1 for one cycle, then the FSM SHALL return to IDLE and busy SHALL drop.
REQ-023 When m_data_out is not valid, it SHALL hold its last value; sinks SHALL NOT rely on it.

Reset
REQ-024 On a reset edge, the block SHALL set busy=0, done=0, m_valid_x=0 and m_valid_f=0, clear the read pointers and the state (IDLE), and zero both m_data_out.
REQ-025 Reset mid-stream SHALL abort the stream: the next cycle SHALL show no valid and no done.
REQ-026 Reset SHALL NOT clear memory contents; stored vectors SHALL stay reusable after reset.

Configuration
REQ-027 With FEEDER_PERF_EN defined, the block SHALL add outputs stall_cnt_x and stall_cnt_f (16 bits each); each SHALL count cycles with m_valid=1 and m_ready=0, saturate at 16'hFFFF, clear on reset, and clear on an accepted start.
REQ-028 Without FEEDER_PERF_EN, those ports and counters SHALL be absent, with identical streaming behaviour.

Structure
REQ-029 The shared package conv_pkg SHALL hold XSIZE, FSIZE, LOGX and LOGF, the 8-bit signed data_t typedef, and the feeder state enum.
REQ-030 A sub-module feeder_channel (parameters SIZE and LOGSIZE) SHALL implement the memory, read pointer, skid register and valid/ready logic, and SHALL be instantiated twice.

Verification
REQ-031 Load x={10,-20,30,-40,50,60,70,80} and f={10,20,-30,40}, then start with both readies held at 1 -> x appears on 8 consecutive cycles, f on 4, both beginning at start+2; done fires at start+10.
REQ-032 Same vectors with readies randomised 50% -> every element is received exactly once, in order; data is unchanged across every stall; done fires exactly once.
REQ-033 Assert start during STREAM -> it is ignored, with no extra elements and one done.
REQ-034 A load write to x address 0 (value 99) during busy -> it is ignored; the next run sends 10 first.
REQ-035 Reset after 3 x transfers -> valids are low the next cycle, busy=0, no done; a restart sends the full sequence from 10.
REQ-036 With FEEDER_PERF_EN defined and m_ready_x held low for 5 cycles while valid -> stall_cnt_x=5; a new start clears it to 0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_feeder shared package: vector sizes, sample type, FSM states.
// Optional feature macro used by this block: FEEDER_PERF_EN.
package conv_pkg;
  localparam int XSIZE = 8;
  localparam int FSIZE = 4;
  localparam int LOGX  = 3;
  localparam int LOGF  = 2;

  typedef logic signed [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    FINISH
  } feed_state_t;
endpackage

// File: rtl/feeder_channel.sv
// One stream channel: vector memory, read pointer, read stage and output.
// FEEDER_PERF_EN adds a saturating stall counter port.
module feeder_channel
  import conv_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int LOGSIZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               active,
  input  logic               wr_en,
  input  logic [LOGSIZE-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  output logic [7:0]         data_out,
  output logic               valid,
  input  logic               ready,
  output logic               complete
`ifdef FEEDER_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);
  localparam logic [LOGSIZE:0] SZ   = (LOGSIZE+1)'(SIZE);
  localparam logic [LOGSIZE:0] LAST = (LOGSIZE+1)'(SIZE-1);

  data_t            mem [SIZE];
  data_t            rd_q;
  logic             rd_vld;
  logic             rd_last;
  logic             out_last;
  logic             fin;
  logic [LOGSIZE:0] ptr;
  logic             xfer;
  logic             load;
  logic             issue;

  // read stage doubles as the skid slot so a full-rate stream has no gaps
  always_comb begin
    xfer     = valid & ready;
    load     = rd_vld & (~valid | ready);
    issue    = active & (ptr < SZ) & (~rd_vld | load);
    complete = fin | (xfer & out_last);
  end

  // storage and registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_t'(wr_data);
    if (issue) rd_q <= mem[ptr[LOGSIZE-1:0]];
  end

  // pointer, read-stage and output-stage control
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
      out_last <= 1'b0;
      fin      <= 1'b0;
    end else if (clr) begin
      ptr      <= '0;
      rd_vld   <= 1'b0;
      valid    <= 1'b0;
      out_last <= 1'b0;
      fin      <= 1'b0;
    end else begin
      if (issue) begin
        ptr     <= ptr + 1'b1;
        rd_last <= (ptr == LAST);
      end
      if (issue)     rd_vld <= 1'b1;
      else if (load) rd_vld <= 1'b0;
      if (load) begin
        data_out <= rd_q;
        valid    <= 1'b1;
        out_last <= rd_last;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer && out_last) fin <= 1'b1;
    end
  end

`ifdef FEEDER_PERF_EN
  // count cycles where the sink holds off a valid word
  always_ff @(posedge clk) begin
    if (reset || clr)
      stall_cnt <= '0;
    else if (valid && !ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/conv_feeder.sv
// Streams a stored x vector and f vector on two valid/ready channels.
// Define FEEDER_PERF_EN to add per-channel stall counters.
module conv_feeder #(
  parameter int XSIZE = conv_pkg::XSIZE,
  parameter int FSIZE = conv_pkg::FSIZE,
  parameter int LOGX  = conv_pkg::LOGX,
  parameter int LOGF  = conv_pkg::LOGF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_wr_en,
  input  logic            ld_sel,
  input  logic [LOGX-1:0] ld_addr,
  input  logic [7:0]      ld_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [7:0]      m_data_out_x,
  output logic            m_valid_x,
  input  logic            m_ready_x,
  output logic [7:0]      m_data_out_f,
  output logic            m_valid_f,
  input  logic            m_ready_f
`ifdef FEEDER_PERF_EN
  ,
  output logic [15:0]     stall_cnt_x,
  output logic [15:0]     stall_cnt_f
`endif
);
  conv_pkg::feed_state_t state, next;

  logic active;
  logic clr;
  logic cmp_x;
  logic cmp_f;
  logic wr_x;
  logic wr_f;
  logic f_ok;

  // loads only while idle; f writes beyond its length are dropped
  always_comb begin
    f_ok = {1'b0, ld_addr} < (LOGX+1)'(FSIZE);
    wr_x = ld_wr_en & ~busy & ~ld_sel;
    wr_f = ld_wr_en & ~busy & ld_sel & f_ok;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= conv_pkg::IDLE;
    else       state <= next;
  end

  // next state and status outputs
  always_comb begin
    next   = state;
    busy   = 1'b0;
    done   = 1'b0;
    active = 1'b0;
    clr    = 1'b0;
    unique case (state)
      conv_pkg::IDLE: begin
        if (start) begin
          clr  = 1'b1;
          next = conv_pkg::PREFETCH;
        end
      end
      conv_pkg::PREFETCH: begin
        busy   = 1'b1;
        active = 1'b1;
        next   = conv_pkg::STREAM;
      end
      conv_pkg::STREAM: begin
        busy   = 1'b1;
        active = 1'b1;
        if (cmp_x && cmp_f) next = conv_pkg::FINISH;
      end
      conv_pkg::FINISH: begin
        busy = 1'b1;
        done = 1'b1;
        next = conv_pkg::IDLE;
      end
      default: next = conv_pkg::IDLE;
    endcase
  end

  feeder_channel #(
    .SIZE    (XSIZE),
    .LOGSIZE (LOGX)
  ) u_x (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .active   (active),
    .wr_en    (wr_x),
    .wr_addr  (ld_addr),
    .wr_data  (ld_data),
    .data_out (m_data_out_x),
    .valid    (m_valid_x),
    .ready    (m_ready_x),
    .complete (cmp_x)
`ifdef FEEDER_PERF_EN
    ,
    .stall_cnt(stall_cnt_x)
`endif
  );

  feeder_channel #(
    .SIZE    (FSIZE),
    .LOGSIZE (LOGF)
  ) u_f (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .active   (active),
    .wr_en    (wr_f),
    .wr_addr  (ld_addr[LOGF-1:0]),
    .wr_data  (ld_data),
    .data_out (m_data_out_f),
    .valid    (m_valid_f),
    .ready    (m_ready_f),
    .complete (cmp_f)
`ifdef FEEDER_PERF_EN
    ,
    .stall_cnt(stall_cnt_f)
`endif
  );
endmodule

// File: tb/tb_conv_feeder.sv
// Directed self-checking bench for conv_feeder.
// Build with FEEDER_PERF_EN to also exercise the stall counters.
module tb_conv_feeder;
  logic       clk = 1'b0;
  logic       reset;
  logic       ld_wr_en;
  logic       ld_sel;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] m_data_out_x;
  logic       m_valid_x;
  logic       m_ready_x;
  logic [7:0] m_data_out_f;
  logic       m_valid_f;
  logic       m_ready_f;
`ifdef FEEDER_PERF_EN
  logic [15:0] stall_cnt_x;
  logic [15:0] stall_cnt_f;
`endif

  int checks   = 0;
  int failures = 0;
  int nx;
  int nf;
  int ndone;

  logic [7:0] expx [8];
  logic [7:0] expf [4];

  always #5 clk = ~clk;

  conv_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .ld_wr_en     (ld_wr_en),
    .ld_sel       (ld_sel),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .m_data_out_f (m_data_out_f),
    .m_valid_f    (m_valid_f),
    .m_ready_f    (m_ready_f)
`ifdef FEEDER_PERF_EN
    ,
    .stall_cnt_x  (stall_cnt_x),
    .stall_cnt_f  (stall_cnt_f)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [2:0] a,
                      input logic [7:0] d);
    ld_wr_en = 1'b1;
    ld_sel   = sel;
    ld_addr  = a;
    ld_data  = d;
    @(negedge clk);
    ld_wr_en = 1'b0;
  endtask

  // ev: 0 none, 1 extra start at cycle evc, 2 x[0]=99 write at cycle evc
  task automatic run(input bit rnd, input int evc, input int ev);
    bit         rx, rf, pvx, prx, pvf, prf, fin;
    logic [7:0] pdx, pdf;
    nx = 0; nf = 0; ndone = 0;
    pvx = 0; prx = 0; pvf = 0; prf = 0; fin = 0;
    pdx = '0; pdf = '0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      start    = (ev == 1 && c == evc);
      ld_wr_en = (ev == 2 && c == evc);
      ld_sel   = 1'b0;
      ld_addr  = 3'd0;
      ld_data  = 8'd99;
      if (pvx && !prx) begin
        chk("x_hold_valid", m_valid_x, 1);
        chk("x_hold_data", m_data_out_x, pdx);
      end
      if (pvf && !prf) begin
        chk("f_hold_valid", m_valid_f, 1);
        chk("f_hold_data", m_data_out_f, pdf);
      end
      rx = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rf = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready_x = rx;
      m_ready_f = rf;
      if (m_valid_x && rx) begin
        if (nx < 8) chk("x_data", m_data_out_x, expx[nx]);
        else        chk("x_extra", nx, 7);
        nx++;
      end
      if (m_valid_f && rf) begin
        if (nf < 4) chk("f_data", m_data_out_f, expf[nf]);
        else        chk("f_extra", nf, 3);
        nf++;
      end
      if (done) ndone++;
      pvx = m_valid_x; prx = rx; pdx = m_data_out_x;
      pvf = m_valid_f; prf = rf; pdf = m_data_out_f;
      if (!busy) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    start    = 1'b0;
    ld_wr_en = 1'b0;
    chk("run_ended", fin, 1);
    chk("x_count", nx, 8);
    chk("f_count", nf, 4);
    chk("done_count", ndone, 1);
  endtask

  initial begin
    expx = '{8'd10, 8'hEC, 8'd30, 8'hD8, 8'd50, 8'd60, 8'd70, 8'd80};
    expf = '{8'd10, 8'd20, 8'hE2, 8'd40};
    reset     = 1'b1;
    ld_wr_en  = 1'b0;
    ld_sel    = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    start     = 1'b0;
    m_ready_x = 1'b0;
    m_ready_f = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid_x", m_valid_x, 0);
    chk("rst_valid_f", m_valid_f, 0);
    chk("rst_data_x", m_data_out_x, 0);
    chk("rst_data_f", m_data_out_f, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) load(1'b0, 3'(i), expx[i]);
    for (int i = 0; i < 4; i++) load(1'b1, 3'(i), expf[i]);
    load(1'b1, 3'd4, 8'd77);

    m_ready_x = 1'b1;
    m_ready_f = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("t_valid_x", m_valid_x, (k >= 2 && k <= 9));
      chk("t_valid_f", m_valid_f, (k >= 2 && k <= 5));
      chk("t_done", done, (k == 10));
      chk("t_busy", busy, (k <= 10));
      if (k >= 2 && k <= 9) chk("t_data_x", m_data_out_x, expx[k-2]);
      if (k >= 2 && k <= 5) chk("t_data_f", m_data_out_f, expf[k-2]);
      @(negedge clk);
    end

    run(1'b1, 0, 0);
    run(1'b0, 5, 1);
    run(1'b1, 4, 2);
    run(1'b0, 0, 0);

    m_ready_x = 1'b1;
    m_ready_f = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ab_data_x", m_data_out_x, expx[3]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ab_valid_x", m_valid_x, 0);
    chk("ab_valid_f", m_valid_f, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_data_x0", m_data_out_x, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_no_done", done, 0);
      chk("ab_no_valid", m_valid_x, 0);
    end
    run(1'b0, 0, 0);

`ifdef FEEDER_PERF_EN
    m_ready_x = 1'b0;
    m_ready_f = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !m_valid_x; i++) @(negedge clk);
    chk("p_valid_x", m_valid_x, 1);
    repeat (5) @(negedge clk);
    chk("p_stall_x", stall_cnt_x, 5);
    chk("p_stall_f", stall_cnt_f, 0);
    m_ready_x = 1'b1;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("p_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("p_clear_x", stall_cnt_x, 0);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("p_idle2", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
